// File: rtl/vga_frame_sched.sv
// vga_frame_sched: VGA raster timing generator with a small command FIFO.
// Commands queued by the host are released to the rasterizer only during
// vertical blanking. A per-frame budget caps how many ops are issued.
module vga_frame_sched #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_OPS    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_ena,
    input  logic [7:0] i_cmd_in,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    output logic       o_op_valid,
    output logic [7:0] o_op_data,
    input  logic       i_op_ready,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_active,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic       o_frame_start,
    output logic [7:0] o_frame_cnt,
    output logic       o_overflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int CW      = PW + 1;
    localparam int IW      = $clog2(MAX_OPS + 1);

    localparam logic [9:0] L_H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] L_V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] L_H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] L_V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] L_V_ACT_M1 = 10'(V_ACTIVE - 1);
    localparam logic [9:0] L_HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] L_HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] L_VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] L_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CW-1:0] L_DEPTH = CW'(FIFO_DEPTH);
    localparam logic [IW-1:0] L_MAX   = IW'(MAX_OPS);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Registered state
    logic [9:0]    r_x;
    logic [9:0]    r_y;
    logic          r_frame_start;
    logic [7:0]    r_frame_cnt;
    logic          r_overflow;
    state_t        r_state;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [IW-1:0] r_issued;
    logic          r_op_valid;
    logic [7:0]    r_op_data;
    logic [7:0]    r_mem [FIFO_DEPTH];

    // Combinational helpers
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_x_wrap;
    logic          w_y_wrap;
    logic          w_to_drain;
    logic          w_to_frame;
    logic [CW-1:0] w_count_next;
    logic [PW-1:0] w_rd_ptr_next;
    state_t        w_state_next;
    logic [IW-1:0] w_issued_next;
    logic          w_op_valid_next;
    logic [7:0]    w_head_next;

    assign w_full        = (r_count == L_DEPTH);
    assign o_cmd_ready   = i_ena & ~w_full;
    assign w_push        = i_cmd_valid & o_cmd_ready;
    assign w_pop         = i_ena & r_op_valid & i_op_ready;
    assign w_x_wrap      = (r_x == L_H_LAST);
    assign w_y_wrap      = (r_y == L_V_LAST);
    // The coming edge moves the beam to (0, V_ACTIVE): start of vblank.
    assign w_to_drain    = w_x_wrap & (r_y == L_V_ACT_M1);
    // The coming edge moves the beam to (0, 0): start of a new frame.
    assign w_to_frame    = w_x_wrap & w_y_wrap;
    assign w_count_next  = r_count + CW'(w_push) - CW'(w_pop);
    assign w_rd_ptr_next = r_rd_ptr + PW'(w_pop);

    // Next FSM state and issue count; the budget restarts on each DRAIN entry.
    always_comb begin
        w_state_next  = r_state;
        w_issued_next = r_issued + IW'(w_pop);
        case (r_state)
            ST_ACTIVE: begin
                if (w_to_drain) begin
                    w_state_next  = ST_DRAIN;
                    w_issued_next = '0;
                end
            end
            ST_DRAIN: begin
                if (w_to_frame) begin
                    w_state_next = (r_op_valid && !i_op_ready) ? ST_HOLD : ST_ACTIVE;
                end
            end
            ST_HOLD: begin
                if (w_pop) begin
                    if (w_to_drain) begin
                        w_state_next  = ST_DRAIN;
                        w_issued_next = '0;
                    end else begin
                        w_state_next = ST_ACTIVE;
                    end
                end
            end
            default: w_state_next = ST_ACTIVE;
        endcase
    end

    // Look ahead one edge so op_valid/op_data come straight from registers.
    // A byte pushed into an otherwise empty FIFO bypasses the array.
    always_comb begin
        w_op_valid_next = (w_state_next == ST_HOLD) ||
                          ((w_state_next == ST_DRAIN) && (w_count_next != '0) &&
                           (w_issued_next < L_MAX));
        if (w_push && ((r_count - CW'(w_pop)) == '0)) begin
            w_head_next = i_cmd_in;
        end else begin
            w_head_next = r_mem[w_rd_ptr_next];
        end
    end

    // FIFO storage: write-only array, no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_cmd_in;
        end
    end

    // Raster counters, frame bookkeeping, FIFO pointers and the scheduler FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x           <= '0;
            r_y           <= '0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= '0;
            r_overflow    <= 1'b0;
            r_state       <= ST_ACTIVE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_issued      <= '0;
            r_op_valid    <= 1'b0;
            r_op_data     <= '0;
        end else if (i_ena) begin
            r_x <= w_x_wrap ? 10'd0 : r_x + 10'd1;
            if (w_x_wrap) begin
                r_y <= w_y_wrap ? 10'd0 : r_y + 10'd1;
            end
            r_frame_start <= w_to_frame;
            if (w_to_frame) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            if (i_cmd_valid && !o_cmd_ready) begin
                r_overflow <= 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            r_rd_ptr   <= w_rd_ptr_next;
            r_count    <= w_count_next;
            r_state    <= w_state_next;
            r_issued   <= w_issued_next;
            r_op_valid <= w_op_valid_next;
            r_op_data  <= w_op_valid_next ? w_head_next : 8'h00;
        end
    end

    assign o_hsync       = ~((r_x >= L_HS_BEG) && (r_x <= L_HS_END));
    assign o_vsync       = ~((r_y >= L_VS_BEG) && (r_y <= L_VS_END));
    assign o_active      = (r_x < L_H_ACT) && (r_y < L_V_ACT);
    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_frame_start = r_frame_start;
    assign o_frame_cnt   = r_frame_cnt;
    assign o_overflow    = r_overflow;
    assign o_op_valid    = r_op_valid;
    assign o_op_data     = r_op_data;

endmodule

// File: tb/tb_vga_frame_sched.sv
// Testbench for vga_frame_sched using a shrunken raster (24 x 10) so that
// several whole frames fit in a short run. Directed vectors, hand-derived
// expectations and a tiny raster position model.
module tb_vga_frame_sched;

    localparam int HA = 16, HF = 2, HS = 4, HB = 2;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;   // 24
    localparam int VT = VA + VF + VS + VB;   // 10
    localparam int DEP  = 4;
    localparam int MOPS = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] cmd_in = 8'h00;
    logic       cmd_valid = 1'b0;
    logic       op_ready = 1'b0;
    logic       cmd_ready, op_valid, hsync, vsync, active, frame_start, overflow;
    logic [7:0] op_data, frame_cnt;
    logic [9:0] x, y;

    vga_frame_sched #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .FIFO_DEPTH(DEP), .MAX_OPS(MOPS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_ena(ena),
        .i_cmd_in(cmd_in), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .o_op_valid(op_valid), .o_op_data(op_data), .i_op_ready(op_ready),
        .o_hsync(hsync), .o_vsync(vsync), .o_active(active),
        .o_x(x), .o_y(y), .o_frame_start(frame_start),
        .o_frame_cnt(frame_cnt), .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   ex = 0, ey = 0, efc = 0;
    logic efs = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (pos %0d,%0d)", tag, obs, exp, ex, ey);
        end
    endtask

    // One clock; inputs were driven before the edge, outputs sampled 1 ns after.
    task automatic step();
        logic en;
        en = ena && rst_n;
        @(posedge clk);
        #1;
        if (en) begin
            efs = (ex == HT - 1) && (ey == VT - 1);
            if (ex == HT - 1) begin
                ex = 0;
                ey = (ey == VT - 1) ? 0 : ey + 1;
            end else begin
                ex = ex + 1;
            end
            if (efs) efc = (efc + 1) % 256;
        end
    endtask

    task automatic step_chk();
        step();
        chk("x", 32'(x), ex);
        chk("y", 32'(y), ey);
        chk("hsync", 32'(hsync), 32'(!(ex >= HA + HF && ex < HA + HF + HS)));
        chk("vsync", 32'(vsync), 32'(!(ey >= VA + VF && ey < VA + VF + VS)));
        chk("active", 32'(active), 32'(ex < HA && ey < VA));
        chk("frame_start", 32'(frame_start), 32'(efs));
        chk("frame_cnt", 32'(frame_cnt), efc);
    endtask

    task automatic goto(input int tx, input int ty);
        for (int i = 0; i < HT * VT + 1; i++) begin
            if (ex == tx && ey == ty) break;
            step_chk();
        end
    endtask

    // Assert reset between edges, check cleared state, release at a falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        ex = 0; ey = 0; efc = 0; efs = 1'b0;
        #1;
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_hsync", 32'(hsync), 1);
        chk("rst_vsync", 32'(vsync), 1);
        chk("rst_active", 32'(active), 1);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_op_valid", 32'(op_valid), 0);
        chk("rst_op_data", 32'(op_data), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        chk("rst_frame_start", 32'(frame_start), 0);
        chk("rst_overflow", 32'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int     bad;
    int     pops, pops_act, pushed;
    logic   ph, pp;
    logic [7:0] q[$];

    // One cycle of the budget test: scoreboard pushes and pops around an edge.
    task automatic io_cycle(inout int npop);
        cmd_valid = (pushed < 20);
        cmd_in    = 8'(8'h40 + pushed);
        #0;
        ph = cmd_valid && cmd_ready;
        pp = op_valid && op_ready;
        if (pp) begin
            chk("order", 32'(op_data), (q.size() > 0) ? 32'(q[0]) : 32'hFFFF_FFFF);
            if (q.size() > 0) void'(q.pop_front());
            npop++;
        end
        if (ph) begin
            q.push_back(cmd_in);
            pushed++;
        end
        step_chk();
    endtask

    initial begin
        #1;
        do_reset();

        // Free run for two frames: raster, syncs and frame pulses vs model.
        bad = 0;
        repeat (2 * HT * VT) begin
            step_chk();
            if (op_valid) bad++;
        end
        chk("frame_cnt_2frames", 32'(frame_cnt), 2);
        chk("idle_no_ops", bad, 0);

        // Freeze with ena=0 at (10,3); a command pulse must be ignored.
        goto(10, 3);
        ena = 1'b0;
        #1;
        chk("freeze_cmd_ready", 32'(cmd_ready), 0);
        for (int i = 0; i < 100; i++) begin
            cmd_valid = (i == 50);
            cmd_in    = 8'h77;
            step_chk();
        end
        cmd_valid = 1'b0;
        chk("freeze_no_overflow", 32'(overflow), 0);
        ena = 1'b1;
        step_chk();
        chk("resume_x", 32'(x), 11);
        chk("resume_y", 32'(y), 3);
        goto(0, VA);
        chk("freeze_no_write", 32'(op_valid), 0);

        // Fill during active video, overflow on the fifth byte, drain in vblank.
        goto(0, 1);
        for (int i = 0; i < 4; i++) begin
            cmd_in    = 8'(8'h11 * (i + 1));
            cmd_valid = 1'b1;
            #0;
            chk("push_ready", 32'(cmd_ready), 1);
            step_chk();
        end
        chk("full_ready", 32'(cmd_ready), 0);
        chk("ovf_before", 32'(overflow), 0);
        cmd_in = 8'h55;
        step_chk();
        cmd_valid = 1'b0;
        chk("ovf_after", 32'(overflow), 1);
        op_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < HT * VT + 1; i++) begin
            if (ex == 0 && ey == VA) break;
            step_chk();
            if (!(ex == 0 && ey == VA) && op_valid) bad++;
        end
        chk("no_op_in_active", bad, 0);
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 32'(op_valid), 1);
            chk("drain_data", 32'(op_data), 32'(8'(8'h11 * (i + 1))));
            step_chk();
        end
        chk("drain_done", 32'(op_valid), 0);
        chk("drain_ready", 32'(cmd_ready), 1);

        // Op stalled across the frame wrap enters HOLD and stays stable.
        op_ready = 1'b0;
        goto(0, VT - 2);
        cmd_in = 8'hA5; cmd_valid = 1'b1;
        step_chk();
        cmd_valid = 1'b0;
        chk("hold_pre_valid", 32'(op_valid), 1);
        chk("hold_pre_data", 32'(op_data), 32'h A5);
        bad = 0;
        for (int i = 0; i < HT * VT + 1; i++) begin
            if (ex == 0 && ey == 0) break;
            step_chk();
            if (op_valid !== 1'b1 || op_data !== 8'hA5) bad++;
        end
        cmd_in = 8'hB6; cmd_valid = 1'b1;
        step_chk();
        cmd_valid = 1'b0;
        repeat (5) begin
            step_chk();
            if (op_valid !== 1'b1 || op_data !== 8'hA5) bad++;
        end
        chk("hold_stable", bad, 0);
        op_ready = 1'b1;
        step_chk();
        chk("hold_popped", 32'(op_valid), 0);
        bad = 0;
        for (int i = 0; i < HT * VT + 1; i++) begin
            if (ex == 0 && ey == VA) break;
            step_chk();
            if (!(ex == 0 && ey == VA) && op_valid) bad++;
        end
        chk("hold_no_new_issue", bad, 0);
        chk("next_vblank_valid", 32'(op_valid), 1);
        chk("next_vblank_data", 32'(op_data), 32'h B6);
        step_chk();
        chk("next_vblank_done", 32'(op_valid), 0);

        // Per-frame budget: 20 bytes pushed continuously, 5 ops per vblank.
        goto(0, 0);
        pushed = 0;
        for (int f = 0; f < 4; f++) begin
            pops_act = 0;
            for (int i = 0; i < HT * VT + 1; i++) begin
                if (ex == 0 && ey == VA) break;
                io_cycle(pops_act);
            end
            chk("budget_active_pops", pops_act, 0);
            chk("budget_first_valid", 32'(op_valid), 1);
            pops = 0;
            for (int i = 0; i < HT * VT + 1; i++) begin
                io_cycle(pops);
                if (ex == 0 && ey == 0) break;
            end
            chk("budget_pops", pops, MOPS);
        end
        cmd_valid = 1'b0;
        chk("budget_pushed", pushed, 20);
        chk("budget_sb_empty", q.size(), 0);

        // Reset in the middle of DRAIN with three entries queued.
        op_ready = 1'b0;
        goto(0, 4);
        for (int i = 0; i < 3; i++) begin
            cmd_in = 8'(8'hC1 + i); cmd_valid = 1'b1;
            step_chk();
        end
        cmd_valid = 1'b0;
        goto(0, VA);
        step_chk();
        chk("pre_rst_valid", 32'(op_valid), 1);
        chk("pre_rst_data", 32'(op_data), 32'h C1);
        do_reset();
        op_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < HT * VT + 1; i++) begin
            if (ex == 0 && ey == VA) break;
            step_chk();
            if (op_valid) bad++;
        end
        repeat (3) begin
            step_chk();
            if (op_valid) bad++;
        end
        chk("post_rst_no_ops", bad, 0);
        chk("post_rst_ready", 32'(cmd_ready), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_frame_sched.md
VGA_FRAME_SCHED -- requirements
Module: vga_frame_sched

Interface
REQ-001 SHALL have parameters: H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48 (H_TOTAL 800); V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33 (V_TOTAL 525); FIFO_DEPTH 4, a power of two and at least 2; MAX_OPS 16, the per-frame issue budget.
REQ-002 SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n as in the codebase.
REQ-003 clk  in  1  system clock; one pixel per cycle.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 ena  in  1  design enable; 0 freezes all state.
REQ-006 cmd_in  in  8  command byte from host.
REQ-007 cmd_valid  in  1  cmd_in is valid.
REQ-008 cmd_ready  out  1  FIFO accepts cmd_in.
REQ-009 op_valid  out  1  op_data is presented to the rasterizer.
REQ-010 op_data  out  8  head-of-FIFO command.
REQ-011 op_ready  in  1  rasterizer accepts op_data.
REQ-012 hsync, vsync  out  1 each  active-low sync outputs.
REQ-013 active  out  1  pixel is in the visible area.
REQ-014 x, y  out  10 each  current pixel coordinates.
REQ-015 frame_start  out  1  one-cycle pulse at frame wrap.
REQ-016 frame_cnt  out  8  frame counter; wraps from 255 to 0.
REQ-017 overflow  out  1  sticky flag for a dropped command.

Function
REQ-018 With ena=1, x SHALL increment every cycle and wrap from H_TOTAL-1 to 0; y SHALL increment on that x wrap and wrap from V_TOTAL-1 to 0.
REQ-019 hsync SHALL be 0 when x is in [656, 751] and 1 otherwise; vsync SHALL be 0 when y is in [490, 491] and 1 otherwise.
REQ-020 active SHALL be 1 when x<640 and y<480; hsync, vsync and active SHALL decode combinationally from the registered x and y.
REQ-021 frame_start SHALL be registered and high for exactly the one cycle in which (x,y) first equals (0,0) after a wrap from (799,524).
REQ-022 frame_cnt SHALL increment in the same cycle as frame_start.
REQ-023 Push: cmd_ready = ena and FIFO not full; a byte SHALL be written when cmd_valid and cmd_ready are both 1.
REQ-024 When the FIFO is full, a simultaneous pop SHALL NOT enable a push in the same cycle.
REQ-025 overflow SHALL set when ena=1, cmd_valid=1 and cmd_ready=0, and SHALL clear only on reset.
REQ-026 The FSM SHALL have three states, transitioning as follows:
- ACTIVE: op_valid=0; SHALL move to DRAIN on the edge where (x,y) becomes (0,480).
- DRAIN: op_valid = FIFO not empty and issued<MAX_OPS; SHALL pop on op_valid and op_ready; SHALL leave on the edge where (x,y) becomes (0,0), going to HOLD if op_valid=1 and op_ready=0 on that edge, otherwise to ACTIVE.
- HOLD: op_valid=1 with op_data unchanged; SHALL pop and move to ACTIVE on op_ready=1; SHALL issue no new op.
REQ-027 Once op_valid is asserted, op_valid and op_data SHALL stay stable until accepted.
REQ-028 An op entering HOLD SHALL count against the budget of the frame in which it was first presented.
REQ-029 The issued counter SHALL clear on entry to DRAIN and increment per pop; FIFO order SHALL be preserved.
REQ-030 Simultaneous push and pop when not full SHALL leave the occupancy unchanged.
REQ-031 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-032 With ena=0, counters, FSM, FIFO and all outputs SHALL hold, except cmd_ready, which SHALL be 0; no push or pop SHALL occur.

Reset
REQ-033 While rst_n=0, all state SHALL clear immediately: x=0, y=0, FSM=ACTIVE, FIFO empty, issued=0, frame_cnt=0, overflow=0, frame_start=0, op_valid=0, op_data=0.
REQ-034 Following from REQ-033, outputs during reset SHALL be hsync=1, vsync=1, active=1 and cmd_ready=1.
REQ-035 Reset asserted in the middle of a DRAIN or HOLD SHALL discard the pending op and all FIFO contents.
REQ-036 Reset deassertion SHALL take effect on the next clk edge.

Verification
REQ-037 Free-run after reset -> hsync low exactly 96 cycles per 800-cycle line; vsync low for 1600 cycles; frame_start period 420000 cycles; frame_cnt=1 after the first wrap.
REQ-038 During active video push 0x11,0x22,0x33,0x44, then 0x55 -> cmd_ready=0 after the 4th push; overflow=1; op_valid=0 until (0,480); then with op_ready=1 op_data is 0x11..0x44 on 4 consecutive cycles.
REQ-039 Push 20 bytes across blanking with op_ready=1 (FIFO refilled continuously) -> exactly 16 ops issued in that frame; the rest are issued from (0,480) of the next frame.
REQ-040 Hold op_ready=0 from (799,520) through (0,0) with 0xA5 at the head -> FSM enters HOLD; op_valid and op_data=0xA5 stay stable; the pop occurs on the first op_ready=1; no further op is issued before the next vblank.
REQ-041 ena=0 for 100 cycles at (300,200) -> x, y and outputs frozen; cmd_ready=0; a cmd_valid pulse is neither written nor flagged as overflow; resumes at (301,200).
REQ-042 Assert rst_n=0 in DRAIN with 3 entries queued -> op_valid=0 and x=y=0 immediately; after release no op issues until (0,480) and the FIFO is empty.
